cpu_ctrl: RTL

- Multi-cycle fetch/decode/execute/writeback sequencer for the 4-bit CPU. Sits directly upstream of the 4x4-bit register file and drives all of its control and data inputs.
- Fetches 8-bit instructions from an external instruction ROM addressed by pc.
- Reads operands back through the register file's two combinational read ports.
- Contains a 4-bit add/sub ALU and Z/C flags; its result feeds the register file write port.

---
 rtl/cpu_ctrl_if.sv | 28 ++
 rtl/cpu_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_if.sv
// Bundle of the sequencer's instruction ROM, register file and status signals.
// master = cpu_ctrl side, slave = ROM/register-file side.
interface cpu_ctrl_if #(
    parameter int PC_W = 4
);
    logic [PC_W-1:0] pc;
    logic [7:0]      instr;
    logic [3:0]      out_a;
    logic [3:0]      out_b;
    logic [1:0]      sel_a;
    logic [1:0]      sel_b;
    logic            write_en;
    logic [1:0]      sel_w;
    logic [3:0]      data_in;
    logic            zero;
    logic            carry;
    logic            halted;

    modport master (
        output pc, sel_a, sel_b, write_en, sel_w, data_in, zero, carry, halted,
        input  instr, out_a, out_b
    );

    modport slave (
        input  pc, sel_a, sel_b, write_en, sel_w, data_in, zero, carry, halted,
        output instr, out_a, out_b
    );
endinterface

// File: rtl/cpu_ctrl.sv
// Fetch/decode/execute/writeback sequencer for the 4-bit CPU; drives the 4x4 register file.
// state  | meaning
// FETCH  | latch instr into IR
// DECODE | drive register file read selects from IR
// EXEC   | register ALU result and flags; arm the write for WB
// WB     | register file write pulse; pc update
// HALT   | terminal until rst
module cpu_ctrl #(
    parameter int PC_W = 4
) (
    input  logic      clk,
    input  logic      rst,
    cpu_ctrl_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [1:0] OP_LDI = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_CTL = 2'd3;

    localparam logic [1:0] SUB_JMP  = 2'd0;
    localparam logic [1:0] SUB_JZ   = 2'd1;
    localparam logic [1:0] SUB_HALT = 2'd3;

    logic [2:0]      state;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic [1:0]      sel_a;
    logic [1:0]      sel_b;
    logic [1:0]      sel_w;
    logic [3:0]      data_in;
    logic            write_en;
    logic            zero;
    logic            carry;
    logic            halted;

    logic [1:0] op;
    logic [1:0] subop;
    logic [3:0] imm;
    logic [4:0] alu;

    assign op    = ir[7:6];
    assign subop = ir[5:4];
    assign imm   = ir[3:0];

    // Bit 4 is carry-out for ADD and borrow (rd < rs) for SUB.
    always_comb begin
        alu = 5'd0;
        case (op)
            OP_LDI:  alu = {1'b0, imm};
            OP_ADD:  alu = {1'b0, bus.out_a} + {1'b0, bus.out_b};
            OP_SUB:  alu = {1'b0, bus.out_a} - {1'b0, bus.out_b};
            default: alu = 5'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir       <= 8'd0;
            sel_a    <= 2'd0;
            sel_b    <= 2'd0;
            sel_w    <= 2'd0;
            data_in  <= 4'd0;
            write_en <= 1'b0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            halted   <= 1'b0;
        end else begin
            write_en <= 1'b0;
            case (state)
                S_FETCH: begin
                    ir    <= bus.instr;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    sel_a <= ir[5:4];
                    sel_b <= ir[3:2];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    // data_in doubles as the result register so it is stable during WB.
                    if (op != OP_CTL) begin
                        data_in  <= alu[3:0];
                        zero     <= (alu[3:0] == 4'd0);
                        write_en <= 1'b1;
                        sel_w    <= ir[5:4];
                        if (op != OP_LDI) begin
                            carry <= alu[4];
                        end
                    end
                    state <= S_WB;
                end
                S_WB: begin
                    if (op == OP_CTL && subop == SUB_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_FETCH;
                        if (op == OP_CTL && (subop == SUB_JMP || (subop == SUB_JZ && zero))) begin
                            pc <= PC_W'(imm);
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    assign bus.pc       = pc;
    assign bus.sel_a    = sel_a;
    assign bus.sel_b    = sel_b;
    assign bus.sel_w    = sel_w;
    assign bus.data_in  = data_in;
    assign bus.write_en = write_en;
    assign bus.zero     = zero;
    assign bus.carry    = carry;
    assign bus.halted   = halted;
endmodule
